// File: rtl/deintv2_pair_swap_pkg.sv
// Shared OFDM constants for the pair-swap deinterleaver.
// Holds the block period, the swap point and the modulation map encodings.
package deintv2_pair_swap_pkg;

  localparam int OFDM_BLK_BITS   = 24;
  localparam int OFDM_SWAP_START = 12;

  typedef enum logic [1:0] {
    MAP_BPSK  = 2'b00,
    MAP_QPSK  = 2'b01,
    MAP_16QAM = 2'b10,
    MAP_64QAM = 2'b11
  } map_type_e;

endpackage

// File: rtl/deintv2_pair_swap_wrap_counter.sv
// Modulo-N enable counter: advances on en and wraps from N-1 back to 0.
module wrap_counter #(
  parameter int N = 24,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         cnt_last
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign cnt_last = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt_last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/deintv2_pair_swap.sv
// Serial 2-bit deinterleaver: gathers bit pairs and re-emits them, reversing
// each pair whose output position lies in the upper part of the block.
module deintv2_pair_swap
  import deintv2_pair_swap_pkg::*;
#(
  parameter int PAIR_W     = 2,
  parameter int BLK_BITS   = OFDM_BLK_BITS,
  parameter int SWAP_START = OFDM_SWAP_START
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic       m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  input  logic [7:0] symb_cnt_in,
  input  logic [1:0] map_type_in,
  output logic [7:0] symb_cnt_out,
  output logic [1:0] map_type_out
);

  localparam int CNT_W = (BLK_BITS > 1) ? $clog2(BLK_BITS) : 1;
  localparam logic [CNT_W-1:0] SWAP_POS = CNT_W'(SWAP_START);

  logic [PAIR_W-1:0] col_data_p0;
  logic [1:0]        col_cnt_p0;
  logic              col_full_p0;
  logic [PAIR_W-1:0] em_data_p1;
  logic [1:0]        em_rem_p1;
  logic              swap_p1;
  logic              vld_p1;
  logic              rdy_en;

  logic              in_hs;
  logic              out_hs;
  logic              em_last_hs;
  logic              pair_xfer;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_last;
  logic [CNT_W-1:0]  next_pos;
  logic [CNT_W-1:0]  start_pos;
  logic              swap_next;
  logic              first_bit;
  logic              sel_bit;

  wrap_counter #(
    .N (BLK_BITS),
    .W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (out_hs),
    .cnt      (cnt),
    .cnt_last (cnt_last)
  );

  assign col_full_p0 = (col_cnt_p0 == 2'd2);
  assign vld_p1      = (em_rem_p1 != 2'd0);
  assign in_hs       = s_axis_tvalid & s_axis_tready;
  assign out_hs      = m_axis_tvalid & m_axis_tready;
  assign em_last_hs  = out_hs & (em_rem_p1 == 2'd1);
  assign pair_xfer   = col_full_p0 & (~vld_p1 | em_last_hs);

  // rdy_en keeps tready low while reset is asserted without a combinational reset path.
  assign s_axis_tready = rdy_en & (~col_full_p0 | pair_xfer);

  // The pair's first output bit lands on cnt, or on cnt+1 when the previous
  // pair's last bit leaves on the same edge.
  assign next_pos  = cnt_last ? '0 : cnt + 1'b1;
  assign start_pos = vld_p1 ? next_pos : cnt;
  assign swap_next = (start_pos >= SWAP_POS);

  assign first_bit     = (em_rem_p1 == 2'd2);
  assign sel_bit       = (first_bit ^ swap_p1) ? em_data_p1[0] : em_data_p1[1];
  assign m_axis_tvalid = vld_p1;
  assign m_axis_tdata  = vld_p1 & sel_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  // Stage p0: collect two serial bits, first bit into bit0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_data_p0 <= '0;
      col_cnt_p0  <= 2'd0;
    end else if (pair_xfer && in_hs) begin
      col_data_p0[0] <= s_axis_tdata;
      col_cnt_p0     <= 2'd1;
    end else if (pair_xfer) begin
      col_cnt_p0 <= 2'd0;
    end else if (in_hs) begin
      col_data_p0[col_cnt_p0[0]] <= s_axis_tdata;
      col_cnt_p0                 <= col_cnt_p0 + 2'd1;
    end
  end

  // Stage p1: emit the held pair in natural or reversed order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em_data_p1 <= '0;
      em_rem_p1  <= 2'd0;
      swap_p1    <= 1'b0;
    end else if (pair_xfer) begin
      em_data_p1 <= col_data_p0;
      em_rem_p1  <= 2'd2;
      swap_p1    <= swap_next;
    end else if (out_hs) begin
      em_rem_p1 <= em_rem_p1 - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      symb_cnt_out <= 8'd0;
      map_type_out <= 2'd0;
    end else begin
      symb_cnt_out <= symb_cnt_in;
      map_type_out <= map_type_in;
    end
  end

endmodule

// File: tb/tb_deintv2_pair_swap.sv
// Scoreboard bench for deintv2_pair_swap: directed streams with hand-derived expectations.
module tb_deintv2_pair_swap;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_tdata = 1'b0;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic       m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b1;
  logic [7:0] symb_in = 8'd0;
  logic [1:0] map_in = 2'd0;
  logic [7:0] symb_out;
  logic [1:0] map_out;

  always #5 clk = ~clk;

  deintv2_pair_swap dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .symb_cnt_in   (symb_in),
    .map_type_in   (map_in),
    .symb_cnt_out  (symb_out),
    .map_type_out  (map_out)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  bit exp_q[$];
  int exp_pos = 0;
  bit pend = 1'b0;
  bit have_pend = 1'b0;

  bit out_log[64];
  int log_n = 0;
  int first_vld_cyc = -1;
  int first_hs_cyc = -1;
  int last_hs_cyc = -1;
  int first_acc = -1;
  int last_acc = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: output position p within a 24-bit block reverses its pair when p >= 12.
  task automatic push_pair(input bit b0, input bit b1);
    if ((exp_pos % 24) >= 12) begin
      exp_q.push_back(b1);
      exp_q.push_back(b0);
    end else begin
      exp_q.push_back(b0);
      exp_q.push_back(b1);
    end
    exp_pos = (exp_pos + 2) % 24;
  endtask

  task automatic send_bit(input bit b);
    int t;
    s_tdata  = b;
    s_tvalid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!s_tready && t < 200);
    if (!s_tready) begin
      chk("send_timeout", 32'd0, 32'd1);
      s_tvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (first_acc < 0) first_acc = cyc;
    last_acc = cyc;
    if (have_pend) begin
      push_pair(pend, b);
      have_pend = 1'b0;
    end else begin
      pend = b;
      have_pend = 1'b1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    chk("drain_left", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard on every output handshake and checks hold-under-stall.
  initial begin
    bit   stall_prev;
    logic prev_data;
    bit   e;
    stall_prev = 1'b0;
    prev_data  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall_vld", m_tvalid, 32'd1);
          chk("stall_data", m_tdata, prev_data);
        end
        if (m_tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("out_bit", m_tdata, e);
          end
          if (log_n < 64) out_log[log_n] = m_tdata;
          log_n++;
          if (first_hs_cyc < 0) first_hs_cyc = cyc;
          last_hs_cyc = cyc;
        end
        stall_prev = m_tvalid && !m_tready;
        prev_data  = m_tdata;
      end
    end
  end

  initial begin
    logic [23:0] got24;
    logic [11:0] got12, want12;
    logic [3:0]  got4;
    logic [47:0] pat2;
    logic [11:0] pat3;
    int t;
    pat2 = 48'hC3A5_96F0_1E7B;
    pat3 = 12'b1011_0010_1101;

    // Reset state, with sideband inputs nonzero to show the outputs are forced.
    symb_in = 8'h5A;
    map_in  = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", s_tready, 32'd0);
    chk("rst_m_tvalid", m_tvalid, 32'd0);
    chk("rst_m_tdata", m_tdata, 32'd0);
    chk("rst_symb_out", symb_out, 32'd0);
    chk("rst_map_out", map_out, 32'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    symb_in = 8'd0;
    map_in  = 2'd0;

    // "10" x 12 -> "10" x 6 then "01" x 6.
    log_n = 0; first_vld_cyc = -1; first_acc = -1;
    for (int i = 0; i < 24; i++) send_bit((i % 2) == 0);
    s_tvalid = 1'b0;
    drain();
    chk("t1_latency", first_vld_cyc - first_acc, 32'd2);
    chk("t1_count", log_n, 32'd24);
    for (int k = 0; k < 24; k++) got24[k] = out_log[k];
    chk("t1_pattern", got24, 32'h00AAA555);

    // 48 continuous bits: one bit per clock, wrap at bit 24.
    log_n = 0; first_hs_cyc = -1; first_acc = -1;
    for (int i = 0; i < 48; i++) send_bit(pat2[i]);
    s_tvalid = 1'b0;
    drain();
    chk("t2_count", log_n, 32'd48);
    chk("t2_out_span", last_hs_cyc - first_hs_cyc, 32'd47);
    chk("t2_in_span", last_acc - first_acc, 32'd47);
    for (int k = 0; k < 12; k++) begin
      got12[k]  = out_log[24 + k];
      want12[k] = pat2[24 + k];
    end
    chk("t2_unswapped_24_35", got12, want12);
    for (int k = 0; k < 12; k++) begin
      got12[k]  = out_log[12 + k];
      want12[k] = pat2[12 + (k ^ 1)];
    end
    chk("t2_swapped_12_23", got12, want12);

    // Downstream stall for 5 clocks in the middle of a pair.
    log_n = 0;
    fork
      begin
        for (int i = 0; i < 12; i++) send_bit(pat3[i]);
        s_tvalid = 1'b0;
      end
      begin
        t = 0;
        while (log_n < 1 && t < 200) begin
          @(posedge clk);
          #1;
          t++;
        end
        chk("t3_first_out", (log_n >= 1), 32'd1);
        m_tready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t3_s_tready_low", s_tready, 32'd0);
        chk("t3_m_tvalid_held", m_tvalid, 32'd1);
        @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    drain();
    chk("t3_count", log_n, 32'd12);

    // Three bits then idle: the odd bit waits for its partner.
    log_n = 0;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    s_tvalid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t4_count", log_n, 32'd2);
    chk("t4_m_tvalid", m_tvalid, 32'd0);
    chk("t4_s_tready", s_tready, 32'd1);
    @(posedge clk);
    #1;
    send_bit(1'b1);
    s_tvalid = 1'b0;
    drain();
    chk("t4_count_after", log_n, 32'd4);
    for (int k = 0; k < 4; k++) got4[k] = out_log[k];
    chk("t4_pattern", got4, 32'h7);

    // Reset in mid-stream, then a fresh stream must start unswapped.
    symb_in = 8'hFF;
    map_in  = 2'b11;
    log_n = 0;
    for (int i = 0; i < 24; i++) begin
      send_bit((i % 2) == 0);
      if (log_n >= 7) break;
    end
    chk("t5_reached_bit7", (log_n >= 7), 32'd1);
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    exp_q.delete();
    have_pend = 1'b0;
    exp_pos   = 0;
    #1;
    chk("t5_s_tready", s_tready, 32'd0);
    chk("t5_m_tvalid", m_tvalid, 32'd0);
    chk("t5_m_tdata", m_tdata, 32'd0);
    chk("t5_symb_out", symb_out, 32'd0);
    chk("t5_map_out", map_out, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    symb_in = 8'd0;
    map_in  = 2'd0;
    log_n   = 0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    s_tvalid = 1'b0;
    drain();
    for (int k = 0; k < 4; k++) got4[k] = out_log[k];
    chk("t5_restart", got4, 32'h5);

    // Sideband registered with one clock of latency.
    @(posedge clk);
    #1;
    symb_in = 8'h03;
    map_in  = 2'b10;
    @(negedge clk);
    chk("t6_symb_before", symb_out, 32'h00);
    chk("t6_map_before", map_out, 32'h0);
    @(posedge clk);
    #1;
    chk("t6_symb_after", symb_out, 32'h03);
    chk("t6_map_after", map_out, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/deintv2_pair_swap.md
DEINTV2_PAIR_SWAP -- requirements
Module: deintv2_pair_swap

Interface
REQ-001 SHALL have parameter PAIR_W, default 2: bits per serial-to-parallel group (fixed to 2 in this release).
REQ-002 SHALL have parameter BLK_BITS, default 24: output-bit period of the swap pattern.
REQ-003 SHALL have parameter SWAP_START, default 12: first output-bit index within a block where pairs are emitted reversed; must be even and less than BLK_BITS.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk input 1 is the single clock; rst_n input 1 is the asynchronous active-low reset.
REQ-005 SHALL have port s_axis_tdata, input, 1 bit: serial coded bit in.
REQ-006 SHALL have port s_axis_tvalid, input, 1 bit: input bit valid.
REQ-007 SHALL have port s_axis_tready, output, 1 bit: block accepts input bit.
REQ-008 SHALL have port m_axis_tdata, output, 1 bit: serial deinterleaved bit out.
REQ-009 SHALL have port m_axis_tvalid, output, 1 bit: output bit valid.
REQ-010 SHALL have port m_axis_tready, input, 1 bit: downstream accepts output bit.
REQ-011 SHALL have port symb_cnt_in, input, 8 bits: OFDM symbol counter sideband.
REQ-012 SHALL have port map_type_in, input, 2 bits: modulation map type sideband.
REQ-013 SHALL have port symb_cnt_out, output, 8 bits: registered symb_cnt_in.
REQ-014 SHALL have port map_type_out, output, 2 bits: registered map_type_in.

Function
REQ-015 Input handshake SHALL be s_axis_tvalid & s_axis_tready; output handshake SHALL be m_axis_tvalid & m_axis_tready.
REQ-016 Collect stage SHALL store accepted bits LSB-first: the first bit of a pair goes to bit0, the second to bit1.
REQ-017 When the collect stage holds a full pair, it SHALL move to the emit stage on the clock edge where the emit stage is empty, or where its last bit handshakes.
REQ-018 s_axis_tready SHALL be high when the collect stage is not full, or when its pair transfers this cycle, giving sustained 1 bit/clock.
REQ-019 The output counter cnt (0..BLK_BITS-1) SHALL increment on each output handshake and wrap from BLK_BITS-1 to 0; it SHALL not change otherwise.
REQ-020 The swap flag SHALL be latched when a pair enters the emit stage: swap = (cnt value at that pair's first output bit >= SWAP_START).
REQ-021 If swap = 0, the emit stage SHALL output bit0 then bit1.
REQ-022 If swap = 1, the emit stage SHALL output bit1 then bit0.
REQ-023 m_axis_tvalid SHALL be high when the emit stage holds unsent bits.
REQ-024 m_axis_tdata and m_axis_tvalid SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-025 Latency SHALL be: first output bit valid one clock after the second bit of its pair is accepted.
REQ-026 Odd trailing bit: a single collected bit SHALL be held indefinitely until its partner arrives; no flush.
REQ-027 symb_cnt_out and map_type_out SHALL register their inputs every clock, with 1-cycle latency and independent of handshakes.
REQ-028 Simultaneous input accept, pair transfer and output handshake in one cycle SHALL all take effect with no bit lost or duplicated.

Reset
REQ-029 rst_n low SHALL asynchronously clear the collect stage, emit stage, cnt and swap flag, and set symb_cnt_out=0 and map_type_out=0.
REQ-030 During reset SHALL hold s_axis_tready=0 and m_axis_tvalid=0, with m_axis_tdata=0.
REQ-031 Reset asserted mid-block SHALL discard partial pairs; after release, cnt restarts at 0.

Structure
REQ-032 BLK_BITS, SWAP_START and the map-type encodings (00 BPSK, 01 QPSK, 10 16QAM, 11 64QAM) SHALL live in the shared OFDM package.
REQ-033 The mod-N enable counter SHALL be one sub-module, wrap_counter, with ports clk, rst_n, en, cnt and cnt_last; collect and emit stages SHALL be inline.

Verification
REQ-034 A bench SHALL apply reset then stream 24 bits "10"x12 with m_axis_tready=1 -> required output "10"x6 then "01"x6, first bit valid 2 clocks after first input accept.
REQ-035 A bench SHALL apply 48 continuous bits with tvalid=1 and tready=1 -> required throughput of 1 bit/clock after fill, cnt wrapping 23->0 at output bit 24, and bits 24..35 unswapped.
REQ-036 A bench SHALL hold m_axis_tready=0 for 5 clocks mid-pair -> required: m_axis_tdata stable, s_axis_tready falls after the collect stage fills, and no bit is lost.
REQ-037 A bench SHALL send 3 bits then stop -> required: 2 bits output, third bit held, m_axis_tvalid=0 afterwards.
REQ-038 A bench SHALL assert rst_n=0 at output bit 7 -> required: all outputs 0 and the next stream starts unswapped from cnt=0.
REQ-039 A bench SHALL drive symb_cnt_in=8'h03 and map_type_in=2'b10 -> required: outputs show the same values 1 clock later.
